// File: rtl/pe_gate_pkg.sv
// Shared types and default constants for the PE clock-gating scheduler.
// Domain states are 2-bit encoded; pe_runnable marks states where the PE clock is usable.
package pe_gate_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WAKE  = 2'd1,
    ST_ON    = 2'd2,
    ST_DRAIN = 2'd3
  } pe_state_e;

  localparam int DEF_NUM_PE      = 4;
  localparam int DEF_IDLE_CYCLES = 8;
  localparam int DEF_WAKE_CYCLES = 2;

  function automatic logic pe_runnable(input pe_state_e s);
    return (s == ST_ON) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/pe_gate_fsm.sv
// One gated PE domain: OFF/WAKE/ON/DRAIN sequencing with wake and idle down-counters.
// en_nxt is the next-state clock enable; the scheduler registers it (and applies bypass).
module pe_gate_fsm
  import pe_gate_pkg::*;
#(
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      start,
  input  logic      finish,
  input  logic      grant,
  output pe_state_e state,
  output logic      en_nxt,
  output logic      ready
);

  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);

  pe_state_e         state_r;
  pe_state_e         state_nxt_s;
  logic [IDLE_W-1:0] idle_cnt_r;
  logic [IDLE_W-1:0] idle_cnt_nxt_s;
  logic [WAKE_W-1:0] wake_cnt_r;
  logic [WAKE_W-1:0] wake_cnt_nxt_s;
  logic              ready_r;

  // Next-state and counter update; start wins over a coincident finish.
  always_comb begin
    state_nxt_s    = state_r;
    idle_cnt_nxt_s = idle_cnt_r;
    wake_cnt_nxt_s = wake_cnt_r;
    case (state_r)
      ST_OFF: begin
        if (grant) begin
          state_nxt_s    = ST_WAKE;
          wake_cnt_nxt_s = WAKE_W'(WAKE_CYCLES);
        end else begin
          state_nxt_s    = ST_OFF;
        end
      end
      ST_WAKE: begin
        if (wake_cnt_r <= WAKE_W'(1)) begin
          state_nxt_s    = ST_ON;
          wake_cnt_nxt_s = {WAKE_W{1'b0}};
        end else begin
          wake_cnt_nxt_s = wake_cnt_r - WAKE_W'(1);
        end
      end
      ST_ON: begin
        if (finish && !start) begin
          state_nxt_s    = ST_DRAIN;
          idle_cnt_nxt_s = IDLE_W'(IDLE_CYCLES);
        end else begin
          state_nxt_s    = ST_ON;
        end
      end
      ST_DRAIN: begin
        if (start) begin
          state_nxt_s    = ST_ON;
          idle_cnt_nxt_s = {IDLE_W{1'b0}};
        end else if (idle_cnt_r <= IDLE_W'(1)) begin
          state_nxt_s    = ST_OFF;
          idle_cnt_nxt_s = {IDLE_W{1'b0}};
        end else begin
          idle_cnt_nxt_s = idle_cnt_r - IDLE_W'(1);
        end
      end
      default: begin
        state_nxt_s    = ST_OFF;
        idle_cnt_nxt_s = {IDLE_W{1'b0}};
        wake_cnt_nxt_s = {WAKE_W{1'b0}};
      end
    endcase
  end

  // Domain state, counters and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_OFF;
      idle_cnt_r <= {IDLE_W{1'b0}};
      wake_cnt_r <= {WAKE_W{1'b0}};
      ready_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      idle_cnt_r <= idle_cnt_nxt_s;
      wake_cnt_r <= wake_cnt_nxt_s;
      ready_r    <= pe_runnable(state_nxt_s);
    end
  end

  assign state  = state_r;
  assign en_nxt = (state_nxt_s != ST_OFF);
  assign ready  = ready_r;

endmodule

// File: rtl/pe_gate_sched.sv
// PE clock-gating scheduler: per-domain FSMs plus round-robin, one-wake-at-a-time arbitration.
// Optional build macro PE_GATE_BYPASS_EN adds a bypass input that forces every clk_en high.
module pe_gate_sched
  import pe_gate_pkg::*;
#(
  parameter int NUM_PE      = DEF_NUM_PE,
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef PE_GATE_BYPASS_EN
  input  logic              bypass,
`endif
  input  logic [NUM_PE-1:0] start,
  input  logic [NUM_PE-1:0] finish,
  output logic [NUM_PE-1:0] clk_en,
  output logic [NUM_PE-1:0] ready,
  output logic              busy
);

  localparam int PTR_W = $clog2(NUM_PE);

  pe_state_e         state_s [NUM_PE];
  logic [NUM_PE-1:0] en_nxt_s;
  logic [NUM_PE-1:0] off_s;
  logic [NUM_PE-1:0] wake_s;
  logic [NUM_PE-1:0] req_s;
  logic [NUM_PE-1:0] grant_s;
  logic [NUM_PE-1:0] pend_r;
  logic [NUM_PE-1:0] pend_nxt_s;
  logic [NUM_PE-1:0] clk_en_r;
  logic [NUM_PE-1:0] clk_en_nxt_s;
  logic [PTR_W-1:0]  rr_ptr_r;
  logic [PTR_W-1:0]  rr_ptr_nxt_s;
  logic [PTR_W:0]    idx_s;
  logic              found_s;
  logic              busy_r;

  for (genvar i = 0; i < NUM_PE; i++) begin : g_dom
    pe_gate_fsm #(
      .IDLE_CYCLES (IDLE_CYCLES),
      .WAKE_CYCLES (WAKE_CYCLES)
    ) u_fsm (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start[i]),
      .finish (finish[i]),
      .grant  (grant_s[i]),
      .state  (state_s[i]),
      .en_nxt (en_nxt_s[i]),
      .ready  (ready[i])
    );
    assign off_s[i]  = (state_s[i] == ST_OFF);
    assign wake_s[i] = (state_s[i] == ST_WAKE);
  end

  // Round-robin grant of one request per cycle, suppressed while any domain is waking.
  always_comb begin
    req_s        = pend_r | (start & off_s);
    grant_s      = {NUM_PE{1'b0}};
    rr_ptr_nxt_s = rr_ptr_r;
    found_s      = 1'b0;
    idx_s        = {(PTR_W+1){1'b0}};
    if (wake_s == {NUM_PE{1'b0}}) begin
      for (int k = 0; k < NUM_PE; k++) begin
        idx_s = {1'b0, rr_ptr_r} + (PTR_W+1)'(k);
        if (idx_s >= (PTR_W+1)'(NUM_PE)) begin
          idx_s = idx_s - (PTR_W+1)'(NUM_PE);
        end else begin
          idx_s = idx_s;
        end
        if (!found_s && req_s[idx_s[PTR_W-1:0]]) begin
          found_s                      = 1'b1;
          grant_s[idx_s[PTR_W-1:0]]    = 1'b1;
          if (idx_s == (PTR_W+1)'(NUM_PE - 1)) begin
            rr_ptr_nxt_s = {PTR_W{1'b0}};
          end else begin
            rr_ptr_nxt_s = idx_s[PTR_W-1:0] + PTR_W'(1);
          end
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      found_s = 1'b0;
    end
  end

  // Pending requests clear on grant; the enable vector optionally ORs in bypass.
  always_comb begin
    pend_nxt_s   = (pend_r | (start & off_s)) & ~grant_s;
`ifdef PE_GATE_BYPASS_EN
    clk_en_nxt_s = en_nxt_s | {NUM_PE{bypass}};
`else
    clk_en_nxt_s = en_nxt_s;
`endif
  end

  // Arbitration state and registered enable/busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= {PTR_W{1'b0}};
      pend_r   <= {NUM_PE{1'b0}};
      clk_en_r <= {NUM_PE{1'b0}};
      busy_r   <= 1'b0;
    end else begin
      rr_ptr_r <= rr_ptr_nxt_s;
      pend_r   <= pend_nxt_s;
      clk_en_r <= clk_en_nxt_s;
      busy_r   <= (|en_nxt_s) | (|pend_nxt_s);
    end
  end

  assign clk_en = clk_en_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_pe_gate_sched.sv
// Scoreboard bench for pe_gate_sched (default parameters); expected output snapshots are
// queued per cycle and a negedge monitor compares them. Bypass scenario under PE_GATE_BYPASS_EN.
module tb_pe_gate_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] start;
  logic [3:0] finish;
  logic [3:0] clk_en;
  logic [3:0] ready;
  logic       busy;
`ifdef PE_GATE_BYPASS_EN
  logic       bypass;
`endif

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit wake_chk_en = 1'b1;

  typedef struct {
    int         cyc;
    string      nm;
    logic [3:0] en;
    logic [3:0] rd;
    logic       bz;
  } exp_t;

  exp_t sb_q[$];

  pe_gate_sched dut (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef PE_GATE_BYPASS_EN
    .bypass (bypass),
`endif
    .start  (start),
    .finish (finish),
    .clk_en (clk_en),
    .ready  (ready),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare due snapshots each cycle and watch that at most one domain is waking.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        checks++;
        if (e.cyc != cyc || clk_en !== e.en || ready !== e.rd || busy !== e.bz) begin
          failures++;
          $display("FAIL %s cyc=%0d due=%0d: got clk_en=%b ready=%b busy=%b, want clk_en=%b ready=%b busy=%b",
                   e.nm, cyc, e.cyc, clk_en, ready, busy, e.en, e.rd, e.bz);
        end
      end
      if (wake_chk_en) begin
        checks++;
        if ($countones(clk_en & ~ready) > 1) begin
          failures++;
          $display("FAIL wake_inrush cyc=%0d: got %0d domains waking (clk_en=%b ready=%b), want at most 1",
                   cyc, $countones(clk_en & ~ready), clk_en, ready);
        end
      end
    end
  end

  task automatic expect_at(input int c, input string nm, input logic [3:0] en,
                           input logic [3:0] rd, input logic bz);
    exp_t e;
    e.cyc = c;
    e.nm  = nm;
    e.en  = en;
    e.rd  = rd;
    e.bz  = bz;
    sb_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [3:0] s, input logic [3:0] f);
    start  = s;
    finish = f;
    @(posedge clk);
    #1;
    start  = 4'b0000;
    finish = 4'b0000;
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 4'b0000;
    finish = 4'b0000;
`ifdef PE_GATE_BYPASS_EN
    bypass = 1'b0;
`endif
    expect_at(1, "rst_state", 4'b0000, 4'b0000, 1'b0);
    wait_until(3);
    rst_n = 1'b1;

    // Uncontended wake: start at 10, enable at 11, ready at 13; then drain to OFF.
    wait_until(10);
    expect_at(10, "s1_pre",   4'b0000, 4'b0000, 1'b0);
    expect_at(11, "s1_en",    4'b0001, 4'b0000, 1'b1);
    expect_at(12, "s1_wake",  4'b0001, 4'b0000, 1'b1);
    expect_at(13, "s1_ready", 4'b0001, 4'b0001, 1'b1);
    expect_at(22, "s1_drain_last", 4'b0001, 4'b0001, 1'b1);
    expect_at(23, "s1_off",   4'b0000, 4'b0000, 1'b0);
    pulse(4'b0001, 4'b0000);
    wait_until(14);
    pulse(4'b0000, 4'b0001);

    // Reset pulse returns the round-robin pointer to domain 0.
    wait_until(25);
    expect_at(25, "rst_mid", 4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b0;
    wait_until(26);
    rst_n = 1'b1;

    // All four start together: wakes serialised 3 cycles apart in order 0..3.
    wait_until(30);
    expect_at(31, "s2_w0",  4'b0001, 4'b0000, 1'b1);
    expect_at(33, "s2_on0", 4'b0001, 4'b0001, 1'b1);
    expect_at(34, "s2_w1",  4'b0011, 4'b0001, 1'b1);
    expect_at(36, "s2_on1", 4'b0011, 4'b0011, 1'b1);
    expect_at(37, "s2_w2",  4'b0111, 4'b0011, 1'b1);
    expect_at(40, "s2_w3",  4'b1111, 4'b0111, 1'b1);
    expect_at(42, "s2_all", 4'b1111, 4'b1111, 1'b1);
    pulse(4'b1111, 4'b0000);

    // Drain of domain 2: held 8 cycles, OFF on the 9th edge.
    wait_until(45);
    expect_at(46, "s3_drain1", 4'b1111, 4'b1111, 1'b1);
    expect_at(53, "s3_drain8", 4'b1111, 4'b1111, 1'b1);
    expect_at(54, "s3_off",    4'b1011, 4'b1011, 1'b1);
    pulse(4'b0000, 4'b0100);

    // Re-wake domain 2, then start it at drain cycle 5: back ON without a wake.
    wait_until(56);
    expect_at(57, "s3_rewake", 4'b1111, 4'b1011, 1'b1);
    expect_at(59, "s3_reon",   4'b1111, 4'b1111, 1'b1);
    expect_at(61, "s3_drain",  4'b1111, 4'b1111, 1'b1);
    expect_at(66, "s3_ret_on", 4'b1111, 4'b1111, 1'b1);
    expect_at(69, "s3_no_off", 4'b1111, 4'b1111, 1'b1);
    expect_at(71, "s3_stay",   4'b1111, 4'b1111, 1'b1);
    pulse(4'b0100, 4'b0000);
    wait_until(60);
    pulse(4'b0000, 4'b0100);
    wait_until(65);
    pulse(4'b0100, 4'b0000);

    // Coincident start and finish on domain 1 in ON: stays ON.
    wait_until(72);
    expect_at(73, "s4_a", 4'b1111, 4'b1111, 1'b1);
    expect_at(77, "s4_b", 4'b1111, 4'b1111, 1'b1);
    expect_at(81, "s4_c", 4'b1111, 4'b1111, 1'b1);
    expect_at(82, "s4_d", 4'b1111, 4'b1111, 1'b1);
    pulse(4'b0010, 4'b0010);

    // Turn off domains 1 and 3, then reset during wake of 3 with 1 pending.
    wait_until(84);
    expect_at(92, "s5_drain", 4'b1111, 4'b1111, 1'b1);
    expect_at(93, "s5_off13", 4'b0101, 4'b0101, 1'b1);
    pulse(4'b0000, 4'b1010);
    wait_until(95);
    expect_at(96,  "s5_wake3",   4'b1101, 4'b0101, 1'b1);
    expect_at(97,  "s5_async",   4'b0000, 4'b0000, 1'b0);
    expect_at(100, "s5_quiet_a", 4'b0000, 4'b0000, 1'b0);
    expect_at(103, "s5_quiet_b", 4'b0000, 4'b0000, 1'b0);
    expect_at(106, "s5_quiet_c", 4'b0000, 4'b0000, 1'b0);
    pulse(4'b1000, 4'b0000);
    pulse(4'b0010, 4'b0000);
    #2;
    rst_n = 1'b0;
    wait_until(99);
    rst_n = 1'b1;

`ifdef PE_GATE_BYPASS_EN
    // Bypass forces enables high while FSMs stay OFF.
    wait_until(110);
    wake_chk_en = 1'b0;
    expect_at(111, "byp_on",  4'b1111, 4'b0000, 1'b0);
    expect_at(113, "byp_off", 4'b0000, 4'b0000, 1'b0);
    bypass = 1'b1;
    wait_until(112);
    bypass = 1'b0;
`endif

    wait_until(115);
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s: got no sample by cyc=%0d, want sample at cyc=%0d", e.nm, cyc, e.cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
